unum4_bs_pipe: RTL and testbench
================================

UNUM4_BS_PIPE -- requirements
Module: unum4_bs_pipe

Interface
REQ-001 Parameter DATA_W, default 29: operand and result width in bits, 2..64.
REQ-002 Parameter SHIFT_W, default 16: shift-amount width in bits.
REQ-003 Parameter STAGES, default 2: pipeline register stages, 1..ceil(log2(DATA_W)).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operand presented.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 data_in  input  DATA_W  signed operand.
REQ-009 shift  input  SHIFT_W  unsigned shift amount.
REQ-010 left_nright  input  1  1 = left shift, 0 = right shift.
REQ-011 arith  input  1  right shifts only: 1 = sign-fill, 0 = zero-fill.
REQ-012 out_valid  output  1  result presented.
REQ-013 out_ready  input  1  consumer accepts the result this cycle.
REQ-014 data_out  output  DATA_W  shifted result.
REQ-015 sticky  output  1  OR of all bits shifted out, for rounding.

Function
REQ-016 The 1-bit shift levels (1, 2, 4, ...) are split across STAGES registered stages, each stage owning a contiguous group of levels, lowest levels first.
REQ-017 A transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-018 With out_ready held at 1, the result appears with out_valid=1 exactly STAGES cycles after its input transfer.
REQ-019 The pipeline advances when adv = !out_valid | out_ready, and in_ready equals adv.
REQ-020 When adv=0, all stage registers, data_out, sticky and out_valid hold their values.
REQ-021 Bubbles propagate: a stage with no valid operand advances as invalid, and pipeline valids are not compressed.
REQ-022 Left shift: zero-fill from the LSB; sticky = OR of bits shifted out of the MSB end.
REQ-023 Right shift: fill from the MSB with data_in[DATA_W-1] when arith=1, otherwise with 0; sticky = OR of bits shifted out of the LSB end.
REQ-024 If shift >= DATA_W, saturate:
 - left shift or logical right: data_out=0
 - arithmetic right: data_out = all copies of the sign bit
 - sticky = OR of all data_in bits that are not fill bits
REQ-025 Saturation is decided in stage 1 from the full SHIFT_W value; upper shift bits are never silently truncated.
REQ-026 shift=0: data_out=data_in and sticky=0, with the same latency.
REQ-027 Mode bits (left_nright, arith) travel with their operand through the pipeline; a change on the next input never affects an operand already in flight.
REQ-028 Results leave the block in input order, with no loss and no duplication under any out_ready pattern.

Reset
REQ-029 While rst_n=0, every stage valid, out_valid, data_out and sticky are 0, and in_ready=0.
REQ-030 An operand in flight when rst_n falls is discarded and never produced.
REQ-031 in_ready becomes 1 on the first clk edge after rst_n rises.

Verification
REQ-032 The bench SHALL cover the following directed scenarios, with DATA_W=8, SHIFT_W=4, STAGES=2 and out_ready=1 unless stated:
 - V1: data_in=0x96, shift=3, left -> data_out=0xB0, sticky=1, out_valid 2 cycles after transfer.
 - V2: data_in=0x96, shift=2, right, arith=1 -> data_out=0xE5, sticky=1; same with arith=0 -> data_out=0x25, sticky=1.
 - V3: data_in=0x80, shift=9, right, arith=1 -> data_out=0xFF, sticky=0; same with left -> data_out=0x00, sticky=1.
 - V4: four back-to-back operands with out_ready=0 for cycles 2-5 -> in_ready drops, results held stable, all four delivered in order once out_ready=1.
 - V5: rst_n pulsed low with two operands in flight -> out_valid=0 immediately (asynchronously), neither result ever appears, in_ready=1 on the first edge after release.
 - V6: random sweep of 10,000 operands with random out_ready -> every output matches a reference model of REQ-022..REQ-026.

Source files
------------

// File: rtl/unum4_bs_pipe.sv
// unum4_bs_pipe: pipelined barrel shifter with sticky and saturation.
// Shift levels are split across STAGES registers under valid/ready flow.
module unum4_bs_pipe #(
    parameter int DATA_W  = 29,
    parameter int SHIFT_W = 16,
    parameter int STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               left_nright,
    input  logic               arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  data_out,
    output logic               sticky
);
    localparam int LW = $clog2(DATA_W);
    localparam int CW = (SHIFT_W > 7) ? SHIFT_W : 7;

    logic              live_q, live_d;
    logic              adv;
    logic              vld_q  [STAGES];
    logic              vld_d  [STAGES];
    logic [DATA_W-1:0] dat_q  [STAGES];
    logic [DATA_W-1:0] dat_d  [STAGES];
    logic              stk_q  [STAGES];
    logic              stk_d  [STAGES];
    logic [LW-1:0]     amt_q  [STAGES];
    logic [LW-1:0]     amt_d  [STAGES];
    logic              left_q [STAGES];
    logic              left_d [STAGES];
    logic              fill_q [STAGES];
    logic              fill_d [STAGES];

    logic [CW-1:0]     shift_ext;
    logic              sat;
    logic [LW-1:0]     amt0;
    logic              fill0;
    logic [DATA_W-1:0] sat_dat;
    logic              sat_stk;
    logic [DATA_W-1:0] grp_dat;
    logic              grp_stk;

    function automatic int grp_lo(input int s);
        return (s * LW) / STAGES;
    endfunction

    // Applies shift levels lo..hi-1 selected by amount bits a.
    function automatic void shift_grp(
        input  logic [DATA_W-1:0] xi,
        input  logic              si,
        input  logic [LW-1:0]     a,
        input  logic              l,
        input  logic              f,
        input  int                lo,
        input  int                hi,
        output logic [DATA_W-1:0] xo,
        output logic              so
    );
        logic [DATA_W-1:0] ones;
        logic [DATA_W-1:0] m;
        ones = '1;
        xo   = xi;
        so   = si;
        for (int k = 0; k < LW; k++) begin
            if (k >= lo && k < hi && a[k]) begin
                if (l) begin
                    m  = ones >> (1 << k);
                    so = so | (|(xo & ~m));
                    xo = xo << (1 << k);
                end else begin
                    m  = ones << (1 << k);
                    so = so | (|(xo & ~m));
                    xo = (xo >> (1 << k))
                       | (f ? ~(ones >> (1 << k)) : '0);
                end
            end
        end
    endfunction

    assign adv       = ~vld_q[STAGES-1] | out_ready;
    assign in_ready  = live_q & adv;
    assign out_valid = vld_q[STAGES-1];
    assign data_out  = dat_q[STAGES-1];
    assign sticky    = stk_q[STAGES-1];

    always_comb begin
        live_d    = 1'b1;
        shift_ext = CW'(shift);
        sat       = shift_ext >= CW'(DATA_W);
        amt0      = sat ? '0 : shift_ext[LW-1:0];
        fill0     = ~left_nright & arith & data_in[DATA_W-1];
        sat_dat   = fill0 ? '1 : '0;
        // Sign copies are fill, not lost data, for saturated arith shifts.
        sat_stk   = (left_nright | ~arith) ? |data_in
                                           : |data_in[DATA_W-2:0];
        grp_dat   = '0;
        grp_stk   = 1'b0;
        shift_grp(data_in, 1'b0, amt0, left_nright, fill0,
                  grp_lo(0), grp_lo(1), grp_dat, grp_stk);
        for (int s = 0; s < STAGES; s++) begin
            vld_d[s]  = vld_q[s];
            dat_d[s]  = dat_q[s];
            stk_d[s]  = stk_q[s];
            amt_d[s]  = amt_q[s];
            left_d[s] = left_q[s];
            fill_d[s] = fill_q[s];
        end
        if (adv) begin
            vld_d[0]  = in_valid & live_q;
            dat_d[0]  = sat ? sat_dat : grp_dat;
            stk_d[0]  = sat ? sat_stk : grp_stk;
            amt_d[0]  = amt0;
            left_d[0] = left_nright;
            fill_d[0] = fill0;
            for (int s = 1; s < STAGES; s++) begin
                vld_d[s]  = vld_q[s-1];
                amt_d[s]  = amt_q[s-1];
                left_d[s] = left_q[s-1];
                fill_d[s] = fill_q[s-1];
                shift_grp(dat_q[s-1], stk_q[s-1], amt_q[s-1],
                          left_q[s-1], fill_q[s-1],
                          grp_lo(s), grp_lo(s + 1),
                          dat_d[s], stk_d[s]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s]  <= 1'b0;
                dat_q[s]  <= '0;
                stk_q[s]  <= 1'b0;
                amt_q[s]  <= '0;
                left_q[s] <= 1'b0;
                fill_q[s] <= 1'b0;
            end
        end else begin
            live_q <= live_d;
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s]  <= vld_d[s];
                dat_q[s]  <= dat_d[s];
                stk_q[s]  <= stk_d[s];
                amt_q[s]  <= amt_d[s];
                left_q[s] <= left_d[s];
                fill_q[s] <= fill_d[s];
            end
        end
    end
endmodule

// File: tb/tb_unum4_bs_pipe.sv
// tb_unum4_bs_pipe: directed and random checks of unum4_bs_pipe
// against a wide-arithmetic shift model and an in-order scoreboard.
module tb_unum4_bs_pipe;
    localparam int DW = 8;
    localparam int SW = 4;
    localparam int ST = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_in;
    logic [SW-1:0] shift;
    logic          left_nright;
    logic          arith;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic          sticky;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
    } exp_t;

    int     total;
    int     bad;
    int     npop;
    logic   live;
    logic   rnd_on;
    exp_t   q[$];
    logic   hold_f;
    logic [7:0] hold_d;
    logic   hold_s;

    unum4_bs_pipe #(.DATA_W(DW), .SHIFT_W(SW), .STAGES(ST)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .shift(shift),
        .left_nright(left_nright), .arith(arith),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .sticky(sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shift in a double-width word, then split kept and lost halves.
    function automatic exp_t model(input logic [7:0] d, input logic [3:0] sh,
                                   input logic l, input logic a);
        exp_t r;
        logic [15:0] w;
        logic signed [15:0] sw;
        if (sh >= 4'd8) begin
            if (!l && a) begin
                r.d = {8{d[7]}};
                r.s = |d[6:0];
            end else begin
                r.d = 8'h00;
                r.s = |d;
            end
        end else if (l) begin
            w   = {8'h00, d} << sh;
            r.d = w[7:0];
            r.s = |w[15:8];
        end else if (a) begin
            sw  = {d, 8'h00};
            sw  = sw >>> sh;
            r.d = sw[15:8];
            r.s = |sw[7:0];
        end else begin
            w   = {d, 8'h00} >> sh;
            r.d = w[15:8];
            r.s = |w[7:0];
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    // Sampled mid-cycle: what is seen here happens at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            hold_f = 1'b0;
        end else begin
            if (live)
                check("in_ready_adv", in_ready, !out_valid || out_ready);
            if (hold_f) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", data_out, hold_d);
                check("hold_sticky", sticky, hold_s);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    npop++;
                    check("sb_data", data_out, e.d);
                    check("sb_sticky", sticky, e.s);
                end
            end
            hold_f = out_valid && !out_ready;
            hold_d = data_out;
            hold_s = sticky;
            if (in_valid && in_ready)
                q.push_back(model(data_in, shift, left_nright, arith));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_on) out_ready = ($urandom_range(0, 9) < 6);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d, input logic [3:0] s,
                        input logic l, input logic a);
        int n;
        in_valid = 1'b1;
        data_in = d;
        shift = s;
        left_nright = l;
        arith = a;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_one(input string nm, input logic [7:0] d,
                           input logic [3:0] s, input logic l, input logic a,
                           input logic [7:0] ed, input logic es);
        send(d, s, l, a);
        @(negedge clk);
        check({nm, "_lat1"}, out_valid, 0);
        @(negedge clk);
        check({nm, "_lat2"}, out_valid, 1);
        check({nm, "_d"}, data_out, ed);
        check({nm, "_s"}, sticky, es);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check({nm, "_drained"}, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int snap;
        total = 0; bad = 0; npop = 0;
        rnd_on = 1'b0; hold_f = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; data_in = '0; shift = '0;
        left_nright = 1'b0; arith = 1'b0; out_ready = 1'b1;

        e = model(8'h96, 4'd3, 1'b1, 1'b0);
        check("model_v1", e, {8'hB0, 1'b1});
        e = model(8'h96, 4'd2, 1'b0, 1'b1);
        check("model_v2a", e, {8'hE5, 1'b1});
        e = model(8'h96, 4'd2, 1'b0, 1'b0);
        check("model_v2l", e, {8'h25, 1'b1});
        e = model(8'h80, 4'd9, 1'b0, 1'b1);
        check("model_v3a", e, {8'hFF, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        check("rst_ov", out_valid, 0);
        check("rst_rdy", in_ready, 0);
        check("rst_d", data_out, 0);
        check("rst_s", sticky, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rdy_before_edge", in_ready, 0);
        @(posedge clk);
        #1 check("rdy_after_edge", in_ready, 1);

        run_one("v1", 8'h96, 4'd3, 1'b1, 1'b0, 8'hB0, 1'b1);
        run_one("v2a", 8'h96, 4'd2, 1'b0, 1'b1, 8'hE5, 1'b1);
        run_one("v2l", 8'h96, 4'd2, 1'b0, 1'b0, 8'h25, 1'b1);
        run_one("v3a", 8'h80, 4'd9, 1'b0, 1'b1, 8'hFF, 1'b0);
        run_one("v3l", 8'h80, 4'd9, 1'b1, 1'b0, 8'h00, 1'b1);
        run_one("zero_l", 8'h5A, 4'd0, 1'b1, 1'b0, 8'h5A, 1'b0);
        run_one("zero_r", 8'hA5, 4'd0, 1'b0, 1'b1, 8'hA5, 1'b0);
        run_one("r7a", 8'h80, 4'd7, 1'b0, 1'b1, 8'hFF, 1'b0);
        run_one("r8l", 8'h7F, 4'd8, 1'b0, 1'b0, 8'h00, 1'b1);
        run_one("r8a", 8'hC1, 4'd8, 1'b0, 1'b1, 8'hFF, 1'b1);
        run_one("l15", 8'h01, 4'd15, 1'b1, 1'b0, 8'h00, 1'b1);
        run_one("l7", 8'h03, 4'd7, 1'b1, 1'b0, 8'h80, 1'b1);
        run_one("r3a", 8'h7C, 4'd3, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_one("r2l", 8'hF0, 4'd2, 1'b0, 1'b0, 8'h3C, 1'b0);
        run_one("l1a", 8'h81, 4'd1, 1'b1, 1'b1, 8'h02, 1'b1);

        // V4: stall the consumer while four operands stream in.
        snap = npop;
        fork
            begin
                send(8'h96, 4'd3, 1'b1, 1'b0);
                send(8'h96, 4'd2, 1'b0, 1'b1);
                send(8'h80, 4'd9, 1'b0, 1'b1);
                send(8'h3C, 4'd1, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                check("v4_rdy_low", in_ready, 0);
                check("v4_ov", out_valid, 1);
                check("v4_held_d", data_out, 8'hB0);
                check("v4_held_s", sticky, 1);
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("v4");
        check("v4_count", npop - snap, 4);

        // V5: reset with one result held at the output and one behind it.
        out_ready = 1'b0;
        send(8'h11, 4'd1, 1'b1, 1'b0);
        send(8'h22, 4'd2, 1'b0, 1'b0);
        check("v5_pre_ov", out_valid, 1);
        snap = npop;
        #2 rst_n = 1'b0;
        #1;
        check("v5_ov", out_valid, 0);
        check("v5_rdy", in_ready, 0);
        check("v5_d", data_out, 0);
        check("v5_s", sticky, 0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("v5_rdy_pre", in_ready, 0);
        @(posedge clk);
        #1 check("v5_rdy_post", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("v5_idle_ov", out_valid, 0);
        end
        check("v5_no_out", npop - snap, 0);
        @(posedge clk);
        #1;

        // V6: random sweep under random back-pressure.
        rnd_on = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain("v6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
